// File: rtl/hsi_mse_pkg.sv
// Shared constants and operation encoding for the HSI MSE datapath.
//   HM_DATA_WIDTH        default input element width
//   HM_LENGTH_BITS       default vector length / element counter width
//   HM_BUFFER_LENGTH     default FIFO depth (power of two, >= 2)
//   HM_VECTOR_LENGTH_TB  nominal vector length used by benches
//   hm_vop_e             element-wise operation selector
package hsi_mse_pkg;

  localparam int unsigned HM_DATA_WIDTH       = 16;
  localparam int unsigned HM_LENGTH_BITS      = 8;
  localparam int unsigned HM_BUFFER_LENGTH    = 8;
  localparam int unsigned HM_VECTOR_LENGTH_TB = 8;

  typedef enum logic [1:0] {
    HM_VOP_ADD     = 2'd0,
    HM_VOP_SUB     = 2'd1,
    HM_VOP_ABSDIFF = 2'd2,
    HM_VOP_SQDIFF  = 2'd3
  } hm_vop_e;

endpackage

// File: rtl/hm_sync_fifo.sv
// Synchronous FIFO with count-derived registered full/empty.
//   clk, rst_n  clock, async active-low reset
//   wr_en       push wr_data (accepted when not full, or when a pop happens too)
//   rd_en       pop head into registered rd_data (ignored when empty)
//   rd_data     registered popped value, holds between pops, 0 after reset
//   head        combinational view of the current head entry
//   full/empty  registered status
//   count       number of stored entries
module hm_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             wr_ok_c, rd_ok_c;

  // A push into a full FIFO is fine when the same edge frees a slot.
  assign rd_ok_c = rd_en && !empty_q;
  assign wr_ok_c = wr_en && (!full_q || rd_ok_c);
  assign count_d = count_q + CW'(wr_ok_c) - CW'(rd_ok_c);

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers, count and registered status; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      if (wr_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok_c) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign rd_data = rd_data_q;
  assign head    = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/vctr_op_fifo_strm.sv
// Two-vector FIFO stream engine: element pairs from two input FIFOs are
// combined by a latched operation (ADD/SUB/ABSDIFF/SQDIFF) in one pipeline
// stage and queued into a double-width output FIFO.
//   data_in_v1/_en/_full, data_in_v2/_en/_full  input element channels
//   data_out/_en/_empty                          registered result read port
//   vector_length, op_mode, start                job setup (sampled in IDLE)
//   done, idle, ready, error                     registered status
module vctr_op_fifo_strm
  import hsi_mse_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = HM_DATA_WIDTH,
  parameter int unsigned LENGTH_BITS   = HM_LENGTH_BITS,
  parameter int unsigned BUFFER_LENGTH = HM_BUFFER_LENGTH,
  localparam int unsigned OUT_WIDTH    = 2 * DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   data_in_v1_en,
  input  logic [DATA_WIDTH-1:0]  data_in_v1,
  output logic                   data_in_v1_full,
  input  logic                   data_in_v2_en,
  input  logic [DATA_WIDTH-1:0]  data_in_v2,
  output logic                   data_in_v2_full,
  input  logic                   data_out_en,
  output logic [OUT_WIDTH-1:0]   data_out,
  output logic                   data_out_empty,
  input  logic [LENGTH_BITS-1:0] vector_length,
  input  logic [1:0]             op_mode,
  input  logic                   start,
  output logic                   done,
  output logic                   idle,
  output logic                   ready,
  output logic                   error
);

  localparam int unsigned CW = $clog2(BUFFER_LENGTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [LENGTH_BITS-1:0] len_q, len_d;
  hm_vop_e                mode_q, mode_d;
  logic [LENGTH_BITS-1:0] in1_cnt_q, in1_cnt_d;
  logic [LENGTH_BITS-1:0] in2_cnt_q, in2_cnt_d;
  logic [LENGTH_BITS-1:0] out_cnt_q, out_cnt_d;
  logic                   err_q, err_d;
  logic                   idle_q, ready_q, done_q;
  logic                   stage_valid_q;
  logic [OUT_WIDTH-1:0]   stage_data_q;

  logic                   v1_full_c, v2_full_c, v1_empty_c, v2_empty_c, out_empty_c;
  logic [DATA_WIDTH-1:0]  v1_head_c, v2_head_c;
  logic [CW-1:0]          out_count_c;
  logic                   wr1_ok_c, wr2_ok_c, pop_c;
  logic [DATA_WIDTH:0]    diff_c;
  logic [DATA_WIDTH-1:0]  absd_c;
  logic [OUT_WIDTH-1:0]   result_c;

  logic [DATA_WIDTH-1:0]  v1_rd_unused, v2_rd_unused;
  logic [CW-1:0]          v1_cnt_unused, v2_cnt_unused;
  logic [OUT_WIDTH-1:0]   out_head_unused;
  logic                   out_full_unused;

  // Input acceptance: only while computing, with room, and below the job length.
  assign wr1_ok_c = data_in_v1_en && (state_q == ST_COMPUTE) && !v1_full_c
                    && (in1_cnt_q < len_q);
  assign wr2_ok_c = data_in_v2_en && (state_q == ST_COMPUTE) && !v2_full_c
                    && (in2_cnt_q < len_q);

  // Pop only if the output FIFO can also absorb the result already in the stage.
  assign pop_c = !v1_empty_c && !v2_empty_c
                 && ((out_count_c + CW'(stage_valid_q)) < CW'(BUFFER_LENGTH));

  hm_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(BUFFER_LENGTH)) u_fifo_v1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr1_ok_c),
    .wr_data (data_in_v1),
    .rd_en   (pop_c),
    .rd_data (v1_rd_unused),
    .head    (v1_head_c),
    .full    (v1_full_c),
    .empty   (v1_empty_c),
    .count   (v1_cnt_unused)
  );

  hm_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(BUFFER_LENGTH)) u_fifo_v2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr2_ok_c),
    .wr_data (data_in_v2),
    .rd_en   (pop_c),
    .rd_data (v2_rd_unused),
    .head    (v2_head_c),
    .full    (v2_full_c),
    .empty   (v2_empty_c),
    .count   (v2_cnt_unused)
  );

  hm_sync_fifo #(.WIDTH(OUT_WIDTH), .DEPTH(BUFFER_LENGTH)) u_fifo_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (stage_valid_q),
    .wr_data (stage_data_q),
    .rd_en   (data_out_en),
    .rd_data (data_out),
    .head    (out_head_unused),
    .full    (out_full_unused),
    .empty   (out_empty_c),
    .count   (out_count_c)
  );

  // Element-wise operation on the two FIFO heads; the 17-bit diff carries the sign.
  always_comb begin
    result_c = '0;
    diff_c   = {1'b0, v1_head_c} - {1'b0, v2_head_c};
    absd_c   = diff_c[DATA_WIDTH] ? DATA_WIDTH'(-diff_c) : diff_c[DATA_WIDTH-1:0];
    unique case (mode_q)
      HM_VOP_ADD:     result_c = OUT_WIDTH'(v1_head_c) + OUT_WIDTH'(v2_head_c);
      HM_VOP_SUB:     result_c = {{(OUT_WIDTH-DATA_WIDTH-1){diff_c[DATA_WIDTH]}}, diff_c};
      HM_VOP_ABSDIFF: result_c = OUT_WIDTH'(absd_c);
      default:        result_c = OUT_WIDTH'(absd_c) * OUT_WIDTH'(absd_c);
    endcase
  end

  // Next-state and job bookkeeping.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    mode_d    = mode_q;
    err_d     = err_q;
    in1_cnt_d = in1_cnt_q + LENGTH_BITS'(wr1_ok_c);
    in2_cnt_d = in2_cnt_q + LENGTH_BITS'(wr2_ok_c);
    out_cnt_d = out_cnt_q + LENGTH_BITS'(stage_valid_q);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d     = vector_length;
          mode_d    = hm_vop_e'(op_mode);
          err_d     = 1'b0;
          in1_cnt_d = '0;
          in2_cnt_d = '0;
          out_cnt_d = '0;
          state_d   = (vector_length == '0) ? ST_DONE : ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if ((out_cnt_q == len_q) && !stage_valid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_empty_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A dropped write strobe is reported even on the cycle a start clears the flag.
    if ((data_in_v1_en && !wr1_ok_c) || (data_in_v2_en && !wr2_ok_c)) err_d = 1'b1;
  end

  // State, job registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      mode_q    <= HM_VOP_ADD;
      err_q     <= 1'b0;
      in1_cnt_q <= '0;
      in2_cnt_q <= '0;
      out_cnt_q <= '0;
      idle_q    <= 1'b1;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
      in1_cnt_q <= in1_cnt_d;
      in2_cnt_q <= in2_cnt_d;
      out_cnt_q <= out_cnt_d;
      idle_q    <= (state_d == ST_IDLE);
      ready_q   <= (state_d == ST_COMPUTE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  // One-stage result pipeline feeding the output FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
    end else begin
      stage_valid_q <= pop_c;
      if (pop_c) stage_data_q <= result_c;
    end
  end

  assign data_in_v1_full = v1_full_c;
  assign data_in_v2_full = v2_full_c;
  assign data_out_empty  = out_empty_c;
  assign idle            = idle_q;
  assign ready           = ready_q;
  assign done            = done_q;
  assign error           = err_q;

endmodule

// File: tb/tb_vctr_op_fifo_strm.sv
// Self-checking bench for vctr_op_fifo_strm (16-bit data, 4-deep FIFOs).
module tb_vctr_op_fifo_strm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_in_v1_en = 1'b0;
  logic [15:0] data_in_v1 = '0;
  logic        data_in_v1_full;
  logic        data_in_v2_en = 1'b0;
  logic [15:0] data_in_v2 = '0;
  logic        data_in_v2_full;
  logic        data_out_en = 1'b0;
  logic [31:0] data_out;
  logic        data_out_empty;
  logic [7:0]  vector_length = '0;
  logic [1:0]  op_mode = '0;
  logic        start = 1'b0;
  logic        done, idle, ready, error;

  int          n_chk = 0;
  int          n_fail = 0;
  int          va [256];
  int          vb [256];
  logic [31:0] exp_q [$];

  vctr_op_fifo_strm #(.DATA_WIDTH(16), .LENGTH_BITS(8), .BUFFER_LENGTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_in_v1_en   (data_in_v1_en),
    .data_in_v1      (data_in_v1),
    .data_in_v1_full (data_in_v1_full),
    .data_in_v2_en   (data_in_v2_en),
    .data_in_v2      (data_in_v2),
    .data_in_v2_full (data_in_v2_full),
    .data_out_en     (data_out_en),
    .data_out        (data_out),
    .data_out_empty  (data_out_empty),
    .vector_length   (vector_length),
    .op_mode         (op_mode),
    .start           (start),
    .done            (done),
    .idle            (idle),
    .ready           (ready),
    .error           (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic straight from the operation definitions.
  function automatic logic [31:0] ref_op(input int mode, input int a, input int b);
    longint d;
    d = longint'(a) - longint'(b);
    case (mode)
      0:       return 32'(a + b);
      1:       return 32'(d);
      2:       return 32'((d < 0) ? -d : d);
      default: return 32'(d * d);
    endcase
  endfunction

  task automatic build_exp(input int mode, input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(ref_op(mode, va[i], vb[i]));
  endtask

  task automatic do_start(input int mode, input int len);
    op_mode       = 2'(mode);
    vector_length = 8'(len);
    start         = 1'b1;
    @(negedge clk);
    start         = 1'b0;
  endtask

  task automatic load_seq();
    for (int i = 0; i < 8; i++) begin
      va[i] = i + 1;
      vb[i] = i + 9;
    end
  endtask

  // Full job: random write/read gaps, every result checked in order.
  task automatic run_vec(input string tag, input int mode, input int len, input int rd_pct);
    int  i1, i2, cyc;
    bit  rd_pend, saw_done;
    build_exp(mode, len);
    do_start(mode, len);
    check({tag, "_start_err"}, 32'(error), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    i1 = 0; i2 = 0; cyc = 0; rd_pend = 0; saw_done = 0;
    while (exp_q.size() > 0 && cyc < 2000) begin
      data_in_v1_en = 1'b0;
      data_in_v2_en = 1'b0;
      if (i1 < len && !data_in_v1_full && $urandom_range(3) != 0) begin
        data_in_v1_en = 1'b1; data_in_v1 = 16'(va[i1]); i1++;
      end
      if (i2 < len && !data_in_v2_full && $urandom_range(3) != 0) begin
        data_in_v2_en = 1'b1; data_in_v2 = 16'(vb[i2]); i2++;
      end
      data_out_en = ($urandom_range(99) < rd_pct);
      rd_pend     = data_out_en && !data_out_empty;
      @(negedge clk);
      cyc++;
      if (done) saw_done = 1;
      if (rd_pend) check({tag, "_data"}, data_out, exp_q.pop_front());
    end
    data_in_v1_en = 1'b0;
    data_in_v2_en = 1'b0;
    data_out_en   = 1'b0;
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    cyc = 0;
    while (!idle && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done) saw_done = 1;
    end
    check({tag, "_done_seen"}, 32'(saw_done), 32'd1);
    check({tag, "_idle"}, 32'(idle), 32'd1);
    check({tag, "_empty"}, 32'(data_out_empty), 32'd1);
    check({tag, "_err"}, 32'(error), 32'd0);
  endtask

  initial begin
    int cyc, i1, i2, got;
    bit rd_pend;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_empty", 32'(data_out_empty), 32'd1);
    check("rst_v1_full", 32'(data_in_v1_full), 32'd0);
    check("rst_v2_full", 32'(data_in_v2_full), 32'd0);
    check("rst_data", data_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors for each linear mode
    load_seq();
    run_vec("add", 0, 8, 80);
    run_vec("sub", 1, 8, 60);
    run_vec("absdiff", 2, 8, 100);

    // Squared difference corners
    va[0] = 16'hFFFF; vb[0] = 0;
    va[1] = 0;        vb[1] = 16'hFFFF;
    va[2] = 5;        vb[2] = 5;
    run_vec("sqdiff", 3, 3, 70);

    // Random jobs
    for (int k = 0; k < 6; k++) begin
      int len;
      len = $urandom_range(20, 1);
      for (int i = 0; i < len; i++) begin
        va[i] = ($urandom_range(7) == 0) ? 16'hFFFF : int'($urandom_range(16'hFFFF));
        vb[i] = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(16'hFFFF));
      end
      run_vec("rand", int'($urandom_range(3)), len, int'($urandom_range(100, 30)));
    end

    // Backpressure: no reads until input FIFOs fill up
    load_seq();
    build_exp(0, 8);
    do_start(0, 8);
    i1 = 0; i2 = 0; cyc = 0;
    while ((i1 < 8 || i2 < 8) && cyc < 40) begin
      data_in_v1_en = (i1 < 8) && !data_in_v1_full;
      data_in_v2_en = (i2 < 8) && !data_in_v2_full;
      data_in_v1 = 16'(va[i1 % 8]);
      data_in_v2 = 16'(vb[i2 % 8]);
      if (data_in_v1_en) i1++;
      if (data_in_v2_en) i2++;
      @(negedge clk);
      cyc++;
    end
    data_in_v1_en = 1'b0;
    data_in_v2_en = 1'b0;
    check("bp_fill_timeout", 32'(i1 + i2), 32'd16);
    repeat (4) @(negedge clk);
    check("bp_ready", 32'(ready), 32'd1);
    check("bp_done", 32'(done), 32'd0);
    check("bp_out_nonempty", 32'(data_out_empty), 32'd0);
    check("bp_v1_full", 32'(data_in_v1_full), 32'd1);
    check("bp_v2_full", 32'(data_in_v2_full), 32'd1);
    check("bp_err_before", 32'(error), 32'd0);
    data_in_v1_en = 1'b1;
    data_in_v1    = 16'hDEAD;
    @(negedge clk);
    data_in_v1_en = 1'b0;
    check("bp_err_drop", 32'(error), 32'd1);
    // Drain all but the last result
    cyc = 0;
    while (exp_q.size() > 1 && cyc < 100) begin
      data_out_en = 1'b1;
      rd_pend     = !data_out_empty;
      @(negedge clk);
      cyc++;
      if (rd_pend) check("bp_data", data_out, exp_q.pop_front());
    end
    data_out_en = 1'b0;
    repeat (5) @(negedge clk);
    check("bp_hold_done", 32'(done), 32'd1);
    check("bp_hold_idle", 32'(idle), 32'd0);
    check("bp_hold_nonempty", 32'(data_out_empty), 32'd0);
    data_out_en = 1'b1;
    @(negedge clk);
    data_out_en = 1'b0;
    check("bp_last", data_out, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx);
    cyc = 0;
    while (!idle && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_idle", 32'(idle), 32'd1);
    check("bp_err_sticky", 32'(error), 32'd1);

    // Zero length: one DONE cycle, then IDLE
    do_start(0, 0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_idle_lo", 32'(idle), 32'd0);
    check("len0_err_clr", 32'(error), 32'd0);
    @(negedge clk);
    check("len0_done_lo", 32'(done), 32'd0);
    check("len0_idle", 32'(idle), 32'd1);
    data_in_v2_en = 1'b1;
    data_in_v2    = 16'h1234;
    @(negedge clk);
    data_in_v2_en = 1'b0;
    check("idle_wr_err", 32'(error), 32'd1);
    check("idle_wr_empty", 32'(data_out_empty), 32'd1);
    load_seq();
    run_vec("after_err", 0, 8, 90);

    // Reset in the middle of a job after three results
    load_seq();
    build_exp(0, 8);
    do_start(0, 8);
    i1 = 0; got = 0; cyc = 0; rd_pend = 0;
    while (got < 3 && cyc < 100) begin
      data_in_v1_en = (i1 < 8) && !data_in_v1_full && !data_in_v2_full;
      data_in_v2_en = data_in_v1_en;
      data_in_v1    = 16'(va[i1 % 8]);
      data_in_v2    = 16'(vb[i1 % 8]);
      if (data_in_v1_en) i1++;
      data_out_en = 1'b1;
      rd_pend     = !data_out_empty;
      @(negedge clk);
      cyc++;
      if (rd_pend) begin
        check("mid_data", data_out, exp_q.pop_front());
        got++;
      end
    end
    data_in_v1_en = 1'b0;
    data_in_v2_en = 1'b0;
    data_out_en   = 1'b0;
    check("mid_got3", 32'(got), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_idle", 32'(idle), 32'd1);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_empty", 32'(data_out_empty), 32'd1);
    check("mid_rst_data", data_out, 32'd0);
    check("mid_rst_v1_full", 32'(data_in_v1_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec("post_rst", 0, 8, 75);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vctr_op_fifo_strm.md
Name: vctr_op_fifo_strm

Overview:
Parametrised successor of the two-vector FIFO stream adder. Two input FIFOs take element pairs. A runtime-selected element-wise operation (ADD, SUB, ABSDIFF, SQDIFF) runs in a one-stage pipeline, and the results go into a wider output FIFO. It is the per-pixel distance front end for the HSI MSE datapath, and it adds backpressure handling, an error flag and a latched operation mode.

Parameters:
DATA_WIDTH, HM_DATA_WIDTH (16), input element width, unsigned.
LENGTH_BITS, HM_LENGTH_BITS, width of vector_length and element counters.
BUFFER_LENGTH, HM_BUFFER_LENGTH (8), depth of each FIFO; power of two, at least 2.
OUT_WIDTH, 2*DATA_WIDTH (derived localparam, not overridable), result width.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst_n  in  1  asynchronous active-low reset.
data_in_v1_en  in  1  write strobe, vector 1 FIFO.
data_in_v1  in  DATA_WIDTH  vector 1 element.
data_in_v1_full  out  1  vector 1 FIFO full.
data_in_v2_en  in  1  write strobe, vector 2 FIFO.
data_in_v2  in  DATA_WIDTH  vector 2 element.
data_in_v2_full  out  1  vector 2 FIFO full.
data_out_en  in  1  read strobe, output FIFO.
data_out  out  OUT_WIDTH  registered head-of-FIFO result.
data_out_empty  out  1  output FIFO empty.
vector_length  in  LENGTH_BITS  element count, sampled on start.
op_mode  in  2  hm_vop_e operation, sampled on start.
start  in  1  begin operation (honoured in IDLE only).
done  out  1  all results produced.
idle  out  1  FSM in IDLE.
ready  out  1  accepting input (COMPUTE state).
error  out  1  sticky protocol error; cleared on accepted start.

Behaviour:
- Reset (async, any state): FSM goes to IDLE. All FIFOs empty, counters 0, stage_valid 0. Outputs: data_out 0, both *_full 0, data_out_empty 1, idle 1, ready 0, done 0, error 0.
- FSM states: IDLE, COMPUTE, DONE.
- IDLE, start=1: latch vector_length into len_q and op_mode into mode_q, clear error and counters. Next state is COMPUTE, or DONE if vector_length==0.
- COMPUTE: ready=1. When in_cnt==len_q, inputs stop being accepted. When out_cnt==len_q and stage_valid==0, go to DONE.
- DONE: done=1. Stay in DONE until the output FIFO is empty, then go to IDLE.
- start outside IDLE is ignored.
- Input writes: accepted only when ready, the target FIFO is not full, and that channel's in_cnt < len_q; each accept increments that channel's in_cnt. Any other write strobe is dropped and sets error.
- Pop: both input FIFOs pop together when both are non-empty and (out_fifo_count + stage_valid) < BUFFER_LENGTH. This is backpressure only; nothing is ever lost.
- Stage: registers the result and sets stage_valid. Next cycle the result is pushed to the output FIFO and out_cnt increments. Pop and push may occur in the same cycle, so throughput is 1 element/cycle.
- Latency: a pair written at edge t pops at t+1 and is pushed at t+2. data_out_empty is low after edge t+2.
- Arithmetic, with a = v1, b = v2, both unsigned:
  - ADD: zero-extended a+b.
  - SUB: a-b as DATA_WIDTH+1 two's complement, sign-extended to OUT_WIDTH.
  - ABSDIFF: |a-b|, zero-extended.
  - SQDIFF: (a-b)^2, exact in OUT_WIDTH.
  - No saturation in any mode.
- Read: on an edge with data_out_en=1 and the output FIFO non-empty, data_out takes the head value and the FIFO pops.
- Read while empty: ignored, data_out holds, error unchanged.
- Simultaneous push and pop on a full FIFO: both succeed, count is unchanged.
- Pointers wrap modulo BUFFER_LENGTH. Full/empty are derived from a count (or an extra pointer bit).
- *_full and data_out_empty are registered status, valid in every state.

Decomposition:
- hsi_mse_pkg: HM_DATA_WIDTH, HM_LENGTH_BITS, HM_BUFFER_LENGTH, HM_VECTOR_LENGTH_TB, and typedef enum logic [1:0] hm_vop_e {HM_VOP_ADD, HM_VOP_SUB, HM_VOP_ABSDIFF, HM_VOP_SQDIFF}.
- FSM state enum stays local to the module.
- Sub-module hm_sync_fifo (WIDTH, DEPTH): wr_en/rd_en, registered rd_data, full, empty, count. Instantiated three times (2x DATA_WIDTH, 1x OUT_WIDTH).

Test Plan:
- ADD: DATA_WIDTH=16, len 8, v1=1..8, v2=9..16, read on the fly -> data_out 0x0000000A, 0x0000000C, ... 0x00000018 in order. done then idle; error=0.
- SUB and ABSDIFF, same vectors -> SUB gives eight 0xFFFFFFF8; ABSDIFF gives eight 0x00000008.
- SQDIFF corners: pairs (0xFFFF,0), (0,0xFFFF), (5,5) -> 0xFFFE0001, 0xFFFE0001, 0x00000000.
- Backpressure, BUFFER_LENGTH=4, len 8, no reads: stalls with the output FIFO holding 4 results, ready still 1. v1 FIFO fills, then data_in_v1_full=1. Extra write while full -> error=1, no data lost beyond the dropped word. Then drain -> all 8 sums in order; done, then idle only once empty.
- Length 0 start -> done for 1 cycle, then idle. Writes in IDLE -> error=1. A later start clears error.
- rst_n low mid-COMPUTE (after 3 outputs) -> immediately idle=1, data_out_empty=1, data_out=0. A fresh len-8 ADD run then passes.
